// File: rtl/skin_segm_pkg.sv
// Shared constants and saturation helpers for frame_summator.
// Holds the default DATA_W / ACC_W / CNT_W / CH values and two constant
// functions that return the clamp limits for an accumulator of a given width.
// The limit helpers are used only when FRAME_SUMMATOR_SAT_EN is defined.
package skin_segm_pkg;

    localparam int DEF_DATA_W = 10;
    localparam int DEF_ACC_W  = 19;
    localparam int DEF_CNT_W  = 19;
    localparam int DEF_CH     = 2;

    // Largest representable accumulator value, returned in 64 bits.
    // The caller slices the low w bits.
    function automatic logic [63:0] sat_hi(input int w, input bit is_signed);
        if (is_signed)
            return (64'd1 << (w - 1)) - 64'd1;
        else
            return (64'd1 << w) - 64'd1;
    endfunction

    // Smallest representable accumulator value, returned in 64 bits.
    // The caller slices the low w bits.
    function automatic logic [63:0] sat_lo(input int w, input bit is_signed);
        if (is_signed)
            return ~64'd0 << (w - 1);
        else
            return 64'd0;
    endfunction

endpackage

// File: rtl/frame_summator_lane.sv
// Single-channel accumulator for frame_summator.
// Adds one sample per accepted edge and tracks a sticky overflow flag.
// It also presents the frame total that would result if the current edge
// closed the frame.
// Ports:
//   clk, rst      clock, asynchronous active-high reset
//   clr_i         discard the current frame (highest priority)
//   fe_i          frame end; the accumulator restarts from zero
//   ce_i          sample valid
//   a_i           sample for this channel
//   acc_o         running accumulator (register output)
//   total_o       accumulator including this edge's sample, latched by the top on frame end
//   ovf_total_o   sticky overflow including this edge's add
// Optional feature: FRAME_SUMMATOR_SAT_EN clamps the accumulator on overflow.
// Otherwise the accumulator wraps modulo 2^ACC_W.
module frame_summator_lane
    import skin_segm_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ACC_W  = DEF_ACC_W,   // must be >= DATA_W
    parameter int SIGNED = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr_i,
    input  logic              fe_i,
    input  logic              ce_i,
    input  logic [DATA_W-1:0] a_i,
    output logic [ACC_W-1:0]  acc_o,
    output logic [ACC_W-1:0]  total_o,
    output logic              ovf_total_o
);

    localparam bit IS_SIGNED = (SIGNED != 0);
    localparam int EXT_W     = ACC_W + 1 - DATA_W;

    logic [ACC_W-1:0] acc_q;
    logic             sticky_q;
    logic [ACC_W:0]   sample_ext;
    logic [ACC_W:0]   acc_ext;
    logic [ACC_W:0]   sum_ext;
    logic             add_ovf;
    logic [ACC_W-1:0] add_res;

    // Work in ACC_W+1 bits so that the extra top bit carries the unsigned
    // carry or the true sign of the signed result.
    always_comb begin
        sample_ext = IS_SIGNED ? {{EXT_W{a_i[DATA_W-1]}}, a_i} : {{EXT_W{1'b0}}, a_i};
        acc_ext    = IS_SIGNED ? {acc_q[ACC_W-1], acc_q} : {1'b0, acc_q};
        sum_ext    = acc_ext + sample_ext;
        add_ovf    = IS_SIGNED ? (sum_ext[ACC_W] ^ sum_ext[ACC_W-1]) : sum_ext[ACC_W];
    end

`ifdef FRAME_SUMMATOR_SAT_EN
    localparam logic [63:0]      HI_64 = sat_hi(ACC_W, IS_SIGNED);
    localparam logic [63:0]      LO_64 = sat_lo(ACC_W, IS_SIGNED);
    localparam logic [ACC_W-1:0] ACC_HI = HI_64[ACC_W-1:0];
    localparam logic [ACC_W-1:0] ACC_LO = LO_64[ACC_W-1:0];

    // Once clamped, the accumulator holds its limit until clr or frame end.
    // For signed overflow, bit ACC_W of the wide sum gives the true sign of
    // the result, which selects the clamp direction.
    always_comb begin
        if (sticky_q)
            add_res = acc_q;
        else if (add_ovf)
            add_res = (IS_SIGNED && sum_ext[ACC_W]) ? ACC_LO : ACC_HI;
        else
            add_res = sum_ext[ACC_W-1:0];
    end
`else
    assign add_res = sum_ext[ACC_W-1:0];
`endif

    assign total_o     = ce_i ? add_res : acc_q;
    assign ovf_total_o = sticky_q | (ce_i & add_ovf);
    assign acc_o       = acc_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q    <= '0;
            sticky_q <= 1'b0;
        end else if (clr_i || fe_i) begin
            acc_q    <= '0;
            sticky_q <= 1'b0;
        end else if (ce_i) begin
            acc_q    <= add_res;
            sticky_q <= sticky_q | add_ovf;
        end
    end

endmodule

// File: rtl/frame_summator.sv
// Multi-channel frame summator.
// Accumulates CH channels of samples between frame_end pulses.
// On each frame end it latches the per-channel totals, the sample count and
// the overflow flags, and pulses out_valid for one cycle.
// Priority on every edge: clr > frame_end > ce > hold.
// Ports:
//   clk, rst    clock, asynchronous active-high reset
//   ce          sample valid
//   A           packed samples, channel k at [k*DATA_W +: DATA_W]
//   clr         discard the current frame
//   frame_end   close the current frame; a sample on the same edge is included
//   Y           running accumulators
//   sum_out     totals of the last closed frame
//   cnt_out     samples in the last closed frame (saturating)
//   ovf_out     per-channel overflow of the last closed frame
//   out_valid   one-cycle pulse when new results are latched
// Optional feature: FRAME_SUMMATOR_SAT_EN selects a saturating accumulator
// in each lane.
module frame_summator
    import skin_segm_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ACC_W  = DEF_ACC_W,
    parameter int CH     = DEF_CH,
    parameter int CNT_W  = DEF_CNT_W,
    parameter int SIGNED = 0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                ce,
    input  logic [CH*DATA_W-1:0] A,
    input  logic                clr,
    input  logic                frame_end,
    output logic [CH*ACC_W-1:0] Y,
    output logic [CH*ACC_W-1:0] sum_out,
    output logic [CNT_W-1:0]    cnt_out,
    output logic [CH-1:0]       ovf_out,
    output logic                out_valid
);

    logic [CH*ACC_W-1:0] total;
    logic [CH-1:0]       ovf_total;

    generate
        for (genvar gi = 0; gi < CH; gi++) begin : g_lane
            frame_summator_lane #(
                .DATA_W (DATA_W),
                .ACC_W  (ACC_W),
                .SIGNED (SIGNED)
            ) u_lane (
                .clk         (clk),
                .rst         (rst),
                .clr_i       (clr),
                .fe_i        (frame_end),
                .ce_i        (ce),
                .a_i         (A[gi*DATA_W +: DATA_W]),
                .acc_o       (Y[gi*ACC_W +: ACC_W]),
                .total_o     (total[gi*ACC_W +: ACC_W]),
                .ovf_total_o (ovf_total[gi])
            );
        end
    endgenerate

    logic [CNT_W-1:0]    cnt_q;
    logic [CNT_W-1:0]    cnt_inc;
    logic [CNT_W-1:0]    cnt_frame;
    logic [CH*ACC_W-1:0] sum_q;
    logic [CNT_W-1:0]    cnt_out_q;
    logic [CH-1:0]       ovf_q;
    logic                valid_q;

    // The counter sticks at all-ones rather than wrapping.
    assign cnt_inc   = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + CNT_W'(1);
    assign cnt_frame = ce ? cnt_inc : cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q     <= '0;
            sum_q     <= '0;
            cnt_out_q <= '0;
            ovf_q     <= '0;
            valid_q   <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            if (clr) begin
                cnt_q <= '0;
            end else if (frame_end) begin
                sum_q     <= total;
                cnt_out_q <= cnt_frame;
                ovf_q     <= ovf_total;
                valid_q   <= 1'b1;
                cnt_q     <= '0;
            end else if (ce) begin
                cnt_q <= cnt_inc;
            end
        end
    end

    assign sum_out   = sum_q;
    assign cnt_out   = cnt_out_q;
    assign ovf_out   = ovf_q;
    assign out_valid = valid_q;

endmodule

// File: tb/tb_frame_summator.sv
module tb_frame_summator;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ce = 1'b0;
    logic        clr = 1'b0;
    logic        fe = 1'b0;
    logic [19:0] a = '0;

    // default instance: DATA_W=10, ACC_W=19, CH=2, CNT_W=19, unsigned
    logic [37:0] y0, sum0;
    logic [18:0] cnt0;
    logic [1:0]  ovf0;
    logic        ov0;
    // narrow accumulator: ACC_W=12
    logic [23:0] y1, sum1;
    logic [18:0] cnt1;
    logic [1:0]  ovf1;
    logic        ov1;
    // signed samples
    logic [37:0] y2, sum2;
    logic [18:0] cnt2;
    logic [1:0]  ovf2;
    logic        ov2;
    // narrow counter: CNT_W=3
    logic [37:0] y3, sum3;
    logic [2:0]  cnt3;
    logic [1:0]  ovf3;
    logic        ov3;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    frame_summator u_dut (
        .clk(clk), .rst(rst), .ce(ce), .A(a), .clr(clr), .frame_end(fe),
        .Y(y0), .sum_out(sum0), .cnt_out(cnt0), .ovf_out(ovf0), .out_valid(ov0)
    );

    frame_summator #(.ACC_W(12)) u_ovf (
        .clk(clk), .rst(rst), .ce(ce), .A(a), .clr(clr), .frame_end(fe),
        .Y(y1), .sum_out(sum1), .cnt_out(cnt1), .ovf_out(ovf1), .out_valid(ov1)
    );

    frame_summator #(.SIGNED(1)) u_sgn (
        .clk(clk), .rst(rst), .ce(ce), .A(a), .clr(clr), .frame_end(fe),
        .Y(y2), .sum_out(sum2), .cnt_out(cnt2), .ovf_out(ovf2), .out_valid(ov2)
    );

    frame_summator #(.CNT_W(3)) u_cnt (
        .clk(clk), .rst(rst), .ce(ce), .A(a), .clr(clr), .frame_end(fe),
        .Y(y3), .sum_out(sum3), .cnt_out(cnt3), .ovf_out(ovf3), .out_valid(ov3)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        tick();
        tick();
        checks++;
        if ({y0, sum0, cnt0, ovf0, ov0} !== '0) begin
            errors++;
            $display("FAIL reset_state got Y=%h sum=%h cnt=%0d ovf=%b ov=%b want all 0",
                     y0, sum0, cnt0, ovf0, ov0);
        end
        rst = 1'b0;
        $display("reset released");
    endtask

    task automatic test_basic();
        ce = 1'b1;
        a = {10'd3, 10'd10};
        for (int i = 1; i <= 4; i++) begin
            tick();
            checks++;
            if (y0 !== {19'(3 * i), 19'(10 * i)}) begin
                errors++;
                $display("FAIL basic_Y sample %0d got %h want %h", i, y0, {19'(3 * i), 19'(10 * i)});
            end
        end
        ce = 1'b0;
        fe = 1'b1;
        tick();
        fe = 1'b0;
        checks++;
        if ({ov0, sum0, cnt0, ovf0, y0} !== {1'b1, 19'd12, 19'd40, 19'd4, 2'b00, 38'd0}) begin
            errors++;
            $display("FAIL basic_frame got ov=%b sum=%h cnt=%0d ovf=%b Y=%h want ov=1 sum={12,40} cnt=4 ovf=0 Y=0",
                     ov0, sum0, cnt0, ovf0, y0);
        end
        tick();
        checks++;
        if (ov0 !== 1'b0) begin
            errors++;
            $display("FAIL basic_pulse_width got out_valid=%b want 0", ov0);
        end
        $display("frame basic: sum=%h cnt=%0d", sum0, cnt0);
    endtask

    task automatic test_ce_with_fe();
        ce = 1'b1;
        a = {10'd10, 10'd10};
        tick();
        tick();
        a = {10'd5, 10'd5};
        fe = 1'b1;
        tick();
        ce = 1'b0;
        fe = 1'b0;
        checks++;
        if ({ov0, sum0, cnt0, y0} !== {1'b1, 19'd25, 19'd25, 19'd3, 38'd0}) begin
            errors++;
            $display("FAIL ce_with_fe got ov=%b sum=%h cnt=%0d Y=%h want ov=1 sum={25,25} cnt=3 Y=0",
                     ov0, sum0, cnt0, y0);
        end
        $display("frame ce_with_fe: sum=%h cnt=%0d", sum0, cnt0);
    endtask

    task automatic test_overflow();
        logic [11:0] exp_acc;
`ifdef FRAME_SUMMATOR_SAT_EN
        exp_acc = 12'd4095;
`else
        exp_acc = 12'd1019;
`endif
        ce = 1'b1;
        a = {10'd1, 10'd1023};
        for (int i = 0; i < 5; i++) tick();
        ce = 1'b0;
        checks++;
        if (y1 !== {12'd5, exp_acc}) begin
            errors++;
            $display("FAIL ovf_Y got %h want %h", y1, {12'd5, exp_acc});
        end
        fe = 1'b1;
        tick();
        fe = 1'b0;
        checks++;
        if ({ov1, sum1, ovf1, cnt1} !== {1'b1, 12'd5, exp_acc, 2'b01, 19'd5}) begin
            errors++;
            $display("FAIL ovf_frame got ov=%b sum=%h ovf=%b cnt=%0d want ov=1 sum=%h ovf=01 cnt=5",
                     ov1, sum1, ovf1, cnt1, {12'd5, exp_acc});
        end
        checks++;
        if ({sum0, ovf0} !== {19'd5, 19'd5115, 2'b00}) begin
            errors++;
            $display("FAIL wide_no_ovf got sum=%h ovf=%b want sum={5,5115} ovf=00", sum0, ovf0);
        end
        $display("frame overflow: sum=%h ovf=%b", sum1, ovf1);
    endtask

    task automatic test_signed();
        ce = 1'b1;
        a = {10'd100, 10'h3FD};  // ch1 +100, ch0 -3
        for (int i = 0; i < 3; i++) tick();
        checks++;
        if (y2 !== {19'd300, 19'h7FFF7}) begin
            errors++;
            $display("FAIL signed_Y got %h want {300,-9}", y2);
        end
        a = {10'h3CE, 10'd2};    // ch1 -50, ch0 +2
        tick();
        ce = 1'b0;
        fe = 1'b1;
        tick();
        fe = 1'b0;
        checks++;
        if ({ov2, sum2, ovf2, cnt2} !== {1'b1, 19'd250, 19'h7FFF9, 2'b00, 19'd4}) begin
            errors++;
            $display("FAIL signed_frame got ov=%b sum=%h ovf=%b cnt=%0d want sum={250,-7} ovf=00 cnt=4",
                     ov2, sum2, ovf2, cnt2);
        end
        $display("frame signed: sum=%h cnt=%0d", sum2, cnt2);
    endtask

    task automatic test_clr();
        ce = 1'b1;
        a = {10'd4, 10'd4};
        for (int i = 0; i < 3; i++) tick();
        ce = 1'b0;
        clr = 1'b1;
        fe = 1'b1;
        tick();
        clr = 1'b0;
        fe = 1'b0;
        checks++;
        if ({ov0, y0, cnt0} !== {1'b0, 38'd0, 19'd4}) begin
            errors++;
            $display("FAIL clr_over_fe got ov=%b Y=%h cnt=%0d want ov=0 Y=0 cnt=4", ov0, y0, cnt0);
        end
        checks++;
        if (sum2 !== {19'd250, 19'h7FFF9}) begin
            errors++;
            $display("FAIL clr_sum_held got %h want {250,-7}", sum2);
        end
        ce = 1'b1;
        fe = 1'b1;
        a = {10'd7, 10'd7};
        tick();
        ce = 1'b0;
        fe = 1'b0;
        checks++;
        if ({ov0, sum0, cnt0} !== {1'b1, 19'd7, 19'd7, 19'd1}) begin
            errors++;
            $display("FAIL after_clr got ov=%b sum=%h cnt=%0d want sum={7,7} cnt=1", ov0, sum0, cnt0);
        end
        $display("frame after clr: sum=%h cnt=%0d", sum0, cnt0);
    endtask

    task automatic test_back_to_back();
        ce = 1'b1;
        a = {10'd2, 10'd2};
        tick();
        ce = 1'b0;
        fe = 1'b1;
        tick();
        checks++;
        if ({ov0, sum0, cnt0} !== {1'b1, 19'd2, 19'd2, 19'd1}) begin
            errors++;
            $display("FAIL b2b_first got ov=%b sum=%h cnt=%0d want sum={2,2} cnt=1", ov0, sum0, cnt0);
        end
        tick();
        fe = 1'b0;
        checks++;
        if ({ov0, sum0, cnt0} !== {1'b1, 38'd0, 19'd0}) begin
            errors++;
            $display("FAIL b2b_empty got ov=%b sum=%h cnt=%0d want ov=1 sum=0 cnt=0", ov0, sum0, cnt0);
        end
        tick();
        checks++;
        if (ov0 !== 1'b0) begin
            errors++;
            $display("FAIL b2b_pulse_end got out_valid=%b want 0", ov0);
        end
        $display("frames back_to_back done");
    endtask

    task automatic test_cnt_sat();
        ce = 1'b1;
        a = {10'd1, 10'd1};
        for (int i = 0; i < 9; i++) tick();
        ce = 1'b0;
        fe = 1'b1;
        tick();
        fe = 1'b0;
        checks++;
        if ({cnt3, sum3} !== {3'd7, 19'd9, 19'd9}) begin
            errors++;
            $display("FAIL cnt_saturate got cnt=%0d sum=%h want cnt=7 sum={9,9}", cnt3, sum3);
        end
        checks++;
        if (cnt0 !== 19'd9) begin
            errors++;
            $display("FAIL cnt_wide got %0d want 9", cnt0);
        end
        $display("frame cnt_sat: cnt=%0d", cnt3);
    endtask

    task automatic test_reset_mid();
        ce = 1'b1;
        a = {10'd5, 10'd5};
        tick();
        tick();
        ce = 1'b0;
        #3;
        rst = 1'b1;
        #1;
        checks++;
        if ({y0, sum0, cnt0, ovf0, ov0} !== '0) begin
            errors++;
            $display("FAIL async_reset got Y=%h sum=%h cnt=%0d ovf=%b ov=%b want all 0",
                     y0, sum0, cnt0, ovf0, ov0);
        end
        #1;
        rst = 1'b0;
        ce = 1'b1;
        a = {10'd1, 10'd1};
        tick();
        checks++;
        if ({ov0, y0} !== {1'b0, 19'd1, 19'd1}) begin
            errors++;
            $display("FAIL post_reset_first got ov=%b Y=%h want ov=0 Y={1,1}", ov0, y0);
        end
        tick();
        ce = 1'b0;
        fe = 1'b1;
        tick();
        fe = 1'b0;
        checks++;
        if ({ov0, sum0, cnt0} !== {1'b1, 19'd2, 19'd2, 19'd2}) begin
            errors++;
            $display("FAIL post_reset_frame got ov=%b sum=%h cnt=%0d want sum={2,2} cnt=2", ov0, sum0, cnt0);
        end
        $display("frame after reset: sum=%h cnt=%0d", sum0, cnt0);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_ce_with_fe();
        test_overflow();
        test_signed();
        test_clr();
        test_back_to_back();
        test_cnt_sat();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
